wb_shared_bus: RTL and testbench

- Parametrised Wishbone B4 classic-cycle shared-bus interconnect: NUM_M masters, NUM_S slaves, one shared path at a time.
- Round-robin arbitration, LOCK-aware bus hold, address decode to slave select, internal error responder for unmapped addresses, response watchdog.
- Sits between master-side and slave-side wb interfaces; successor to the fixed 1:1 point-to-point master/slave hookup.

---
 rtl/wb_bus_pkg.sv | 26 ++
 rtl/wb_rr_arbiter.sv | 50 +++++
 rtl/wb_shared_bus.sv | 168 ++++++++++++++++
 tb/tb_wb_shared_bus.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_pkg.sv
// Shared types and helpers for the Wishbone shared-bus interconnect.
package wb_bus_pkg;

   typedef enum logic {IDLE, BUSY} bus_state_e;

   localparam int BYTE_W    = 8;
   localparam int MAX_N     = 8;
   localparam int MAX_ADR_W = 64;

   // Lowest set bit wins, so this doubles as a priority encoder.
   function automatic logic [2:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = MAX_N - 1; i >= 0; i--) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic logic addr_hit(input logic [MAX_ADR_W-1:0] adr,
                                     input logic [MAX_ADR_W-1:0] base,
                                     input logic [MAX_ADR_W-1:0] mask);
      return (adr & mask) == base;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin request picker; the pointer advances past a master when it releases the bus.
module wb_rr_arbiter
   import wb_bus_pkg::*;
#(
   parameter int NUM_M = 2,
   parameter int IDX_W = 1
)
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [NUM_M-1:0] req_i,
   input  logic             release_i,
   input  logic [IDX_W-1:0] rel_idx_i,
   output logic [NUM_M-1:0] gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_vld_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [NUM_M-1:0] rot;
   logic [2:0]       off;
   int               sum;

   always_comb begin
      ptr_d = ptr_q;
      if (release_i) begin
         ptr_d = (int'(rel_idx_i) == NUM_M - 1) ? '0 : rel_idx_i + 1'b1;
      end
   end

   // Rotate the requests so the pointer position lands on bit 0.
   always_comb begin
      rot       = NUM_M'({req_i, req_i} >> ptr_q);
      off       = onehot_to_idx(MAX_N'(rot));
      sum       = int'(ptr_q) + int'(off);
      if (sum >= NUM_M) sum = sum - NUM_M;
      gnt_vld_o = |req_i;
      gnt_idx_o = IDX_W'(sum);
      gnt_o     = gnt_vld_o ? (NUM_M'(1) << gnt_idx_o) : '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/wb_shared_bus.sv
// Wishbone classic shared bus: one granted master drives one decoded slave at a time,
// with an internal error responder for unmapped addresses and a response watchdog.
module wb_shared_bus
   import wb_bus_pkg::*;
#(
   parameter int NUM_M = 2,
   parameter int NUM_S = 2,
   parameter int ADR_W = 32,
   parameter int DAT_W = 32,
   parameter logic [NUM_S*ADR_W-1:0] S_BASE = {32'h0001_0000, 32'h0000_0000},
   parameter logic [NUM_S*ADR_W-1:0] S_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
   parameter int TIMEOUT = 16
)
(
   input  logic                         CLK_I,
   input  logic                         RST_I,
   input  logic [NUM_M-1:0]             m_CYC_I,
   input  logic [NUM_M-1:0]             m_STB_I,
   input  logic [NUM_M-1:0]             m_WE_I,
   input  logic [NUM_M-1:0]             m_LOCK_I,
   input  logic [NUM_M*ADR_W-1:0]       m_ADR_I,
   input  logic [NUM_M*DAT_W-1:0]       m_DAT_I,
   input  logic [NUM_M*(DAT_W/8)-1:0]   m_SEL_I,
   output logic [DAT_W-1:0]             m_DAT_O,
   output logic [NUM_M-1:0]             m_ACK_O,
   output logic [NUM_M-1:0]             m_ERR_O,
   output logic [NUM_M-1:0]             m_RTY_O,
   output logic [NUM_S-1:0]             s_CYC_O,
   output logic [NUM_S-1:0]             s_STB_O,
   output logic                         s_WE_O,
   output logic                         s_LOCK_O,
   output logic [ADR_W-1:0]             s_ADR_O,
   output logic [DAT_W-1:0]             s_DAT_O,
   output logic [DAT_W/8-1:0]           s_SEL_O,
   input  logic [NUM_S*DAT_W-1:0]       s_DAT_I,
   input  logic [NUM_S-1:0]             s_ACK_I,
   input  logic [NUM_S-1:0]             s_ERR_I,
   input  logic [NUM_S-1:0]             s_RTY_I
);

   localparam int SEL_W   = DAT_W / BYTE_W;
   localparam int IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int SIDX_W  = (NUM_S > 1) ? $clog2(NUM_S) : 1;
   localparam int WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam bit WD_EN   = (TIMEOUT > 0);

   bus_state_e        state_q;
   logic [IDX_W-1:0]  gnt_q;
   logic [NUM_M-1:0]  gnt_oh_q;
   logic              unmap_q, unmap_d;
   logic [WD_W-1:0]   wd_q, wd_d;

   logic [ADR_W-1:0]  m_adr [NUM_M];
   logic [DAT_W-1:0]  m_dat [NUM_M];
   logic [SEL_W-1:0]  m_sel [NUM_M];
   logic [DAT_W-1:0]  s_dat [NUM_S];

   logic              cyc_g, stb_g, we_g, lock_g;
   logic [ADR_W-1:0]  adr_g;
   logic [NUM_S-1:0]  hit, sel_oh;
   logic [SIDX_W-1:0] sel_idx;
   logic              busy, stb_act, any_hit, route;
   logic              ack_s, err_s, rty_s, slave_resp, wd_expire;

   logic [NUM_M-1:0]  arb_oh;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_vld, release_bus;

   generate
      for (genvar gi = 0; gi < NUM_M; gi++) begin : g_mslice
         assign m_adr[gi] = m_ADR_I[gi*ADR_W +: ADR_W];
         assign m_dat[gi] = m_DAT_I[gi*DAT_W +: DAT_W];
         assign m_sel[gi] = m_SEL_I[gi*SEL_W +: SEL_W];
      end
      for (genvar gi = 0; gi < NUM_S; gi++) begin : g_sslice
         assign s_dat[gi] = s_DAT_I[gi*DAT_W +: DAT_W];
         assign hit[gi]   = addr_hit(MAX_ADR_W'(adr_g),
                                     MAX_ADR_W'(S_BASE[gi*ADR_W +: ADR_W]),
                                     MAX_ADR_W'(S_MASK[gi*ADR_W +: ADR_W]));
      end
   endgenerate

   assign cyc_g  = m_CYC_I[gnt_q];
   assign stb_g  = m_STB_I[gnt_q];
   assign we_g   = m_WE_I[gnt_q];
   assign lock_g = m_LOCK_I[gnt_q];
   assign adr_g  = m_adr[gnt_q];

   // Overlapping windows resolve to the lowest-index slave.
   assign sel_oh  = hit & (~hit + 1'b1);
   assign sel_idx = SIDX_W'(onehot_to_idx(MAX_N'(hit)));
   assign any_hit = |hit;

   assign busy       = (state_q == BUSY);
   assign stb_act    = busy & cyc_g & stb_g;
   assign route      = busy & cyc_g & any_hit;
   assign ack_s      = s_ACK_I[sel_idx];
   assign err_s      = s_ERR_I[sel_idx];
   assign rty_s      = s_RTY_I[sel_idx];
   assign slave_resp = route & (ack_s | err_s | rty_s);
   // Expiry is judged on the counter alone so the slave-side strobe mask never depends on slave replies.
   assign wd_expire  = WD_EN && stb_act && any_hit && (wd_q == WD_W'(WD_LAST));
   assign release_bus = busy & ~cyc_g & ~lock_g;

   wb_rr_arbiter #(
      .NUM_M (NUM_M),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk_i     (CLK_I),
      .rst_n_i   (RST_I),
      .req_i     (m_CYC_I),
      .release_i (release_bus),
      .rel_idx_i (gnt_q),
      .gnt_o     (arb_oh),
      .gnt_idx_o (arb_idx),
      .gnt_vld_o (arb_vld)
   );

   assign s_CYC_O  = (busy & cyc_g) ? sel_oh : '0;
   assign s_STB_O  = (stb_act & ~wd_expire) ? sel_oh : '0;
   assign s_WE_O   = busy & we_g;
   assign s_LOCK_O = busy & lock_g;
   assign s_ADR_O  = busy ? adr_g : '0;
   assign s_DAT_O  = busy ? m_dat[gnt_q] : '0;
   assign s_SEL_O  = busy ? m_sel[gnt_q] : '0;

   assign m_DAT_O = route ? s_dat[sel_idx] : '0;
   assign m_ACK_O = (route & ack_s) ? gnt_oh_q : '0;
   assign m_RTY_O = (route & rty_s) ? gnt_oh_q : '0;
   assign m_ERR_O = ((route & err_s) | (busy & unmap_q) | (wd_expire & ~slave_resp))
                    ? gnt_oh_q : '0;

   always_comb begin
      unmap_d = stb_act & ~any_hit & ~unmap_q;
      wd_d    = '0;
      if (WD_EN && stb_act && any_hit && !slave_resp && !wd_expire) begin
         wd_d = wd_q + 1'b1;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (!RST_I) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         gnt_oh_q <= '0;
         unmap_q  <= 1'b0;
         wd_q     <= '0;
      end else begin
         unmap_q <= unmap_d;
         wd_q    <= wd_d;
         case (state_q)
            IDLE: begin
               if (arb_vld) begin
                  gnt_q    <= arb_idx;
                  gnt_oh_q <= arb_oh;
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               if (release_bus) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Directed bench for wb_shared_bus: arbitration, decode, error responder, lock, watchdog.
module tb_wb_shared_bus;

   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic [1:0]  m_CYC_I, m_STB_I, m_WE_I, m_LOCK_I;
   logic [63:0] m_ADR_I, m_DAT_I;
   logic [7:0]  m_SEL_I;
   logic [31:0] m_DAT_O;
   logic [1:0]  m_ACK_O, m_ERR_O, m_RTY_O;
   logic [1:0]  s_CYC_O, s_STB_O;
   logic        s_WE_O, s_LOCK_O;
   logic [31:0] s_ADR_O, s_DAT_O;
   logic [3:0]  s_SEL_O;
   logic [63:0] s_DAT_I;
   logic [1:0]  s_ACK_I, s_ERR_I, s_RTY_I;

   int total = 0;
   int bad   = 0;

   always #5 CLK_I = ~CLK_I;

   wb_shared_bus #(
      .NUM_M   (2),
      .NUM_S   (2),
      .ADR_W   (32),
      .DAT_W   (32),
      .S_BASE  ({32'h0001_0000, 32'h0000_0000}),
      .S_MASK  ({32'hFFFF_0000, 32'hFFFF_0000}),
      .TIMEOUT (16)
   ) dut (
      .CLK_I    (CLK_I),
      .RST_I    (RST_I),
      .m_CYC_I  (m_CYC_I),
      .m_STB_I  (m_STB_I),
      .m_WE_I   (m_WE_I),
      .m_LOCK_I (m_LOCK_I),
      .m_ADR_I  (m_ADR_I),
      .m_DAT_I  (m_DAT_I),
      .m_SEL_I  (m_SEL_I),
      .m_DAT_O  (m_DAT_O),
      .m_ACK_O  (m_ACK_O),
      .m_ERR_O  (m_ERR_O),
      .m_RTY_O  (m_RTY_O),
      .s_CYC_O  (s_CYC_O),
      .s_STB_O  (s_STB_O),
      .s_WE_O   (s_WE_O),
      .s_LOCK_O (s_LOCK_O),
      .s_ADR_O  (s_ADR_O),
      .s_DAT_O  (s_DAT_O),
      .s_SEL_O  (s_SEL_O),
      .s_DAT_I  (s_DAT_I),
      .s_ACK_I  (s_ACK_I),
      .s_ERR_I  (s_ERR_I),
      .s_RTY_I  (s_RTY_I)
   );

   task automatic next();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic clear_inputs();
      m_CYC_I = '0; m_STB_I = '0; m_WE_I = '0; m_LOCK_I = '0;
      m_ADR_I = '0; m_DAT_I = '0; m_SEL_I = '0;
      s_DAT_I = '0; s_ACK_I = '0; s_ERR_I = '0; s_RTY_I = '0;
   endtask

   task automatic apply_reset();
      RST_I = 1'b0;
      clear_inputs();
      next(); next();
      RST_I = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      #3;
      total++; if (m_ACK_O !== 2'b00) begin bad++; $display("FAIL rst_ack got=%h want=%h", m_ACK_O, 2'b00); end
      total++; if (m_ERR_O !== 2'b00) begin bad++; $display("FAIL rst_err got=%h want=%h", m_ERR_O, 2'b00); end
      total++; if (m_RTY_O !== 2'b00) begin bad++; $display("FAIL rst_rty got=%h want=%h", m_RTY_O, 2'b00); end
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL rst_cyc got=%h want=%h", s_CYC_O, 2'b00); end
      total++; if (s_STB_O !== 2'b00) begin bad++; $display("FAIL rst_stb got=%h want=%h", s_STB_O, 2'b00); end
      total++; if (m_DAT_O !== 32'h0) begin bad++; $display("FAIL rst_dat got=%h want=%h", m_DAT_O, 32'h0); end
      $display("txn reset done");
   endtask

   task automatic test_write();
      next();
      m_CYC_I = 2'b01; m_STB_I = 2'b01; m_WE_I = 2'b01;
      m_ADR_I[31:0] = 32'h0000_0010; m_DAT_I[31:0] = 32'hDEAD_BEEF; m_SEL_I[3:0] = 4'hF;
      #3;
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL wr_arb_latency got=%h want=%h", s_CYC_O, 2'b00); end
      next(); #3;
      total++; if (s_CYC_O !== 2'b01) begin bad++; $display("FAIL wr_cyc got=%h want=%h", s_CYC_O, 2'b01); end
      total++; if (s_STB_O !== 2'b01) begin bad++; $display("FAIL wr_stb got=%h want=%h", s_STB_O, 2'b01); end
      total++; if (s_DAT_O !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_dat got=%h want=%h", s_DAT_O, 32'hDEAD_BEEF); end
      total++; if (s_ADR_O !== 32'h0000_0010) begin bad++; $display("FAIL wr_adr got=%h want=%h", s_ADR_O, 32'h10); end
      total++; if (s_WE_O !== 1'b1) begin bad++; $display("FAIL wr_we got=%h want=%h", s_WE_O, 1'b1); end
      total++; if (m_ACK_O !== 2'b00) begin bad++; $display("FAIL wr_ack_early got=%h want=%h", m_ACK_O, 2'b00); end
      next();
      s_ACK_I = 2'b01;
      #3;
      total++; if (m_ACK_O !== 2'b01) begin bad++; $display("FAIL wr_ack got=%h want=%h", m_ACK_O, 2'b01); end
      next();
      clear_inputs();
      #3;
      total++; if (m_ACK_O !== 2'b00) begin bad++; $display("FAIL wr_ack_once got=%h want=%h", m_ACK_O, 2'b00); end
      next();
      $display("txn M0 write 0x10 <= deadbeef");
   endtask

   task automatic test_round_robin();
      apply_reset();
      m_CYC_I = 2'b11;
      m_ADR_I = {32'h0001_0000, 32'h0000_0000};
      #3;
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL rr_latency got=%h want=%h", s_CYC_O, 2'b00); end
      next(); #3;
      total++; if (s_CYC_O !== 2'b01) begin bad++; $display("FAIL rr_m0_first got=%h want=%h", s_CYC_O, 2'b01); end
      next();
      m_CYC_I = 2'b10;
      #3;
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL rr_m0_drop got=%h want=%h", s_CYC_O, 2'b00); end
      next(); #3;
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL rr_idle_gap got=%h want=%h", s_CYC_O, 2'b00); end
      next(); #3;
      total++; if (s_CYC_O !== 2'b10) begin bad++; $display("FAIL rr_m1_next got=%h want=%h", s_CYC_O, 2'b10); end
      next();
      m_CYC_I = 2'b00;
      next();
      m_CYC_I = 2'b11;
      #3;
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL rr_idle2 got=%h want=%h", s_CYC_O, 2'b00); end
      next(); #3;
      total++; if (s_CYC_O !== 2'b01) begin bad++; $display("FAIL rr_tie_m0 got=%h want=%h", s_CYC_O, 2'b01); end
      next();
      clear_inputs();
      next();
      $display("txn round-robin M0 -> M1 -> M0");
   endtask

   task automatic test_read();
      next();
      m_CYC_I = 2'b10; m_STB_I = 2'b10;
      m_ADR_I[63:32] = 32'h0001_0004;
      s_DAT_I = {32'h1234_5678, 32'hAAAA_5555};
      next();
      s_ACK_I = 2'b10;
      #3;
      total++; if (s_CYC_O !== 2'b10) begin bad++; $display("FAIL rd_cyc got=%h want=%h", s_CYC_O, 2'b10); end
      total++; if (m_DAT_O !== 32'h1234_5678) begin bad++; $display("FAIL rd_dat got=%h want=%h", m_DAT_O, 32'h1234_5678); end
      total++; if (m_ACK_O !== 2'b10) begin bad++; $display("FAIL rd_ack got=%h want=%h", m_ACK_O, 2'b10); end
      next();
      clear_inputs();
      #3;
      total++; if (m_ACK_O !== 2'b00) begin bad++; $display("FAIL rd_ack_once got=%h want=%h", m_ACK_O, 2'b00); end
      next();
      $display("txn M1 read 0x10004 => 12345678");
   endtask

   task automatic test_unmapped();
      next();
      m_CYC_I = 2'b01; m_STB_I = 2'b01;
      m_ADR_I[31:0] = 32'h0002_0000;
      s_DAT_I = {32'h1111_1111, 32'h2222_2222};
      next(); #3;
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL um_no_cyc got=%h want=%h", s_CYC_O, 2'b00); end
      total++; if (m_ERR_O !== 2'b00) begin bad++; $display("FAIL um_err_early got=%h want=%h", m_ERR_O, 2'b00); end
      total++; if (m_DAT_O !== 32'h0) begin bad++; $display("FAIL um_dat got=%h want=%h", m_DAT_O, 32'h0); end
      next(); #3;
      total++; if (m_ERR_O !== 2'b01) begin bad++; $display("FAIL um_err got=%h want=%h", m_ERR_O, 2'b01); end
      next(); #3;
      total++; if (m_ERR_O !== 2'b00) begin bad++; $display("FAIL um_err_gap got=%h want=%h", m_ERR_O, 2'b00); end
      next(); #3;
      total++; if (m_ERR_O !== 2'b01) begin bad++; $display("FAIL um_err_again got=%h want=%h", m_ERR_O, 2'b01); end
      next();
      clear_inputs();
      next();
      $display("txn M0 read unmapped 0x20000 -> err");
   endtask

   task automatic test_lock();
      apply_reset();
      m_CYC_I = 2'b01; m_LOCK_I = 2'b01;
      m_ADR_I = {32'h0001_0000, 32'h0000_0000};
      next(); #3;
      total++; if (s_CYC_O !== 2'b01) begin bad++; $display("FAIL lk_m0 got=%h want=%h", s_CYC_O, 2'b01); end
      total++; if (s_LOCK_O !== 1'b1) begin bad++; $display("FAIL lk_lock got=%h want=%h", s_LOCK_O, 1'b1); end
      next();
      m_CYC_I = 2'b10;
      #3;
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL lk_hold_gap got=%h want=%h", s_CYC_O, 2'b00); end
      next();
      m_CYC_I = 2'b11;
      #3;
      total++; if (s_CYC_O !== 2'b01) begin bad++; $display("FAIL lk_keep_m0 got=%h want=%h", s_CYC_O, 2'b01); end
      next();
      m_CYC_I = 2'b10; m_LOCK_I = 2'b00;
      #3;
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL lk_release got=%h want=%h", s_CYC_O, 2'b00); end
      next(); #3;
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL lk_idle got=%h want=%h", s_CYC_O, 2'b00); end
      next(); #3;
      total++; if (s_CYC_O !== 2'b10) begin bad++; $display("FAIL lk_m1_after got=%h want=%h", s_CYC_O, 2'b10); end
      next();
      clear_inputs();
      next();
      $display("txn M0 locked, M1 granted after release");
   endtask

   task automatic test_timeout();
      logic [1:0] exp_err, exp_stb;
      apply_reset();
      m_CYC_I = 2'b01; m_STB_I = 2'b01;
      m_ADR_I[31:0] = 32'h0000_0004;
      for (int n = 1; n <= 17; n++) begin
         next(); #3;
         exp_err = (n == 16) ? 2'b01 : 2'b00;
         exp_stb = (n == 16) ? 2'b00 : 2'b01;
         total++; if (m_ERR_O !== exp_err) begin bad++; $display("FAIL wd_err_c%0d got=%h want=%h", n, m_ERR_O, exp_err); end
         total++; if (s_STB_O !== exp_stb) begin bad++; $display("FAIL wd_stb_c%0d got=%h want=%h", n, s_STB_O, exp_stb); end
      end
      next(); next();
      RST_I = 1'b0;
      next(); #3;
      total++; if (s_CYC_O !== 2'b00) begin bad++; $display("FAIL wd_rst_cyc got=%h want=%h", s_CYC_O, 2'b00); end
      total++; if (s_STB_O !== 2'b00) begin bad++; $display("FAIL wd_rst_stb got=%h want=%h", s_STB_O, 2'b00); end
      total++; if (m_ERR_O !== 2'b00) begin bad++; $display("FAIL wd_rst_err got=%h want=%h", m_ERR_O, 2'b00); end
      total++; if (m_ACK_O !== 2'b00) begin bad++; $display("FAIL wd_rst_ack got=%h want=%h", m_ACK_O, 2'b00); end
      clear_inputs();
      RST_I = 1'b1;
      next();
      $display("txn M0 watchdog timeout then reset");
   endtask

   task automatic test_ack_vs_timeout();
      apply_reset();
      m_CYC_I = 2'b01; m_STB_I = 2'b01;
      m_ADR_I[31:0] = 32'h0000_0008;
      for (int n = 1; n <= 16; n++) begin
         next();
         if (n == 16) s_ACK_I = 2'b01;
         #3;
      end
      total++; if (m_ACK_O !== 2'b01) begin bad++; $display("FAIL race_ack got=%h want=%h", m_ACK_O, 2'b01); end
      total++; if (m_ERR_O !== 2'b00) begin bad++; $display("FAIL race_err got=%h want=%h", m_ERR_O, 2'b00); end
      next();
      s_ACK_I = 2'b00;
      #3;
      total++; if (m_ERR_O !== 2'b00) begin bad++; $display("FAIL race_after_err got=%h want=%h", m_ERR_O, 2'b00); end
      total++; if (s_STB_O !== 2'b01) begin bad++; $display("FAIL race_after_stb got=%h want=%h", s_STB_O, 2'b01); end
      next();
      clear_inputs();
      next();
      $display("txn ack coincides with watchdog expiry");
   endtask

   initial begin
      clear_inputs();
      RST_I = 1'b0;
      test_reset();
      test_write();
      test_round_robin();
      test_read();
      test_unmapped();
      test_lock();
      test_timeout();
      test_ack_vs_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
